// File: rtl/encoder_phase_ctrl.sv
// Encoder mux sequencing on the clock4x domain: frame-clock cadence lock FSM,
// programmable-delay encoder select, qualified latch strobes and lock-loss counter.
module encoder_phase_ctrl #(
    parameter int PERIOD        = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int DELAY_DEFAULT = 6,
    parameter int ERR_WIDTH     = 8
) (
    input  logic                 clock4x,
    input  logic                 reset,
    input  logic                 frame_clock_sampled,
    input  logic [3:0]           delay_cfg,
    input  logic                 delay_load,
    input  logic                 err_clr,
    output logic                 sel,
    output logic [1:0]           phase,
    output logic                 strobe_even,
    output logic                 strobe_odd,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] err_cnt
);

    localparam int         GW      = $clog2(LOCK_COUNT + 1);
    localparam logic [1:0] PH_LAST = 2'(PERIOD - 1);
    localparam logic [GW-1:0] GC_LAST = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

    state_t               state_q, state_d;
    logic                 fcs_q;
    logic [15:0]          sr_q, sr_d;
    logic [3:0]           delay_q, delay_d;
    logic [3:0]           blank_q, blank_d;
    logic [1:0]           phase_q, phase_d;
    logic [GW-1:0]        good_q, good_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic                 sel_q, sel_d, sel_d1_q;
    logic                 locked_q, locked_d;
    logic                 se_q, se_d, so_q, so_d;

    logic rise, wrap, good, bad, lost, qual;

    always_comb begin
        rise = frame_clock_sampled & ~fcs_q;
        wrap = (phase_q == PH_LAST);
        good = rise & wrap;
        // A rise off-cadence, or a wrap with no rise, both break the frame rhythm.
        bad  = (rise & ~wrap) | (~rise & wrap);

        phase_d = (rise || wrap) ? 2'd0 : phase_q + 2'd1;
        sr_d    = {sr_q[14:0], fcs_q};
        sel_d   = sr_q[delay_q];
        delay_d = delay_load ? delay_cfg : delay_q;
        blank_d = delay_load ? 4'd15 : ((blank_q != 4'd0) ? blank_q - 4'd1 : 4'd0);

        state_d = state_q;
        good_d  = good_q;
        lost    = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (rise) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (bad) begin
                    state_d = UNLOCKED;
                end else if (good) begin
                    good_d = good_q + GW'(1);
                    if (good_q == GC_LAST) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_d = UNLOCKED;
                    lost    = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase

        if (err_clr)                  err_d = '0;
        else if (lost && err_q != '1) err_d = err_q + ERR_WIDTH'(1);
        else                          err_d = err_q;

        locked_d = (state_q == LOCKED);

        // Strobes are suppressed while a freshly loaded tap settles.
        qual = locked_q & (blank_q == 4'd0) & ~delay_load;
        se_d = sel_q & ~sel_d1_q & qual;
        so_d = ~sel_q & sel_d1_q & qual;
    end

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            fcs_q    <= 1'b0;
            sr_q     <= '0;
            delay_q  <= 4'(DELAY_DEFAULT);
            blank_q  <= '0;
            phase_q  <= '0;
            good_q   <= '0;
            err_q    <= '0;
            sel_q    <= 1'b0;
            sel_d1_q <= 1'b0;
            locked_q <= 1'b0;
            se_q     <= 1'b0;
            so_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcs_q    <= frame_clock_sampled;
            sr_q     <= sr_d;
            delay_q  <= delay_d;
            blank_q  <= blank_d;
            phase_q  <= phase_d;
            good_q   <= good_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            sel_d1_q <= sel_q;
            locked_q <= locked_d;
            se_q     <= se_d;
            so_q     <= so_d;
        end
    end

    assign sel         = sel_q;
    assign phase       = phase_q;
    assign strobe_even = se_q;
    assign strobe_odd  = so_q;
    assign locked      = locked_q;
    assign err_cnt     = err_q;

endmodule
